fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end. Replaces the free-running PC register, the "+4" adder and the combinational instruction-memory read.
- Holds a fetch PC, issues in-order requests to an instruction memory with variable latency, and buffers returned instructions with their PCs in a prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Accepts branch/jump redirects from downstream. On a redirect it flushes buffered instructions and discards stale in-flight responses.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum memory requests in flight (≥1).
- RESET_PC, 32'h0000_0000, PC fetched first after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  byte address of requested word.
- imem_rsp_valid  in  1  response word valid; responses are in request order, one per request.
- imem_rsp_data  in  XLEN  returned instruction.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes head.
- instr  out  XLEN  head instruction.
- instr_pc  out  XLEN  PC of head instruction.
- instr_pc_plus4  out  XLEN  instr_pc + 4.
- redirect_valid  in  1  redirect fetch stream.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC and rsp_pc = RESET_PC.
  - FIFO empty, outstanding = 0, discard_cnt = 0.
  - imem_req_valid = 0 and instr_valid = 0 while reset is asserted.
- Reset mid-operation drops everything, including in-flight memory responses. The memory side must be reset together with this block.
- Request issue:
  - imem_req_valid = (outstanding < MAX_OUTSTANDING) && (outstanding + fifo_count < FIFO_DEPTH).
  - imem_req_valid is a function of registered state only and never depends on imem_req_ready.
  - imem_req_addr = fetch_pc.
  - req_fire = valid && ready. On req_fire, fetch_pc += 4, wrapping modulo 2^XLEN.
- The credit rule guarantees the FIFO never overflows, so no response is ever refused.
- outstanding next value = outstanding + req_fire − imem_rsp_valid. This counts stale requests too.
- Response handling:
  - If discard_cnt > 0, the response is dropped and discard_cnt decrements.
  - Otherwise the response pushes {rsp_pc, imem_rsp_data} into the FIFO and rsp_pc += 4.
- Latency: a response in cycle N makes instr_valid high in cycle N+1 at the earliest. There is no bypass.
- First request is issued in the first cycle after reset deasserts.
- Dequeue: pop when instr_valid && instr_ready. Push and pop may occur in the same cycle; count is unchanged.
- FIFO pointers wrap at FIFO_DEPTH.
- Redirect (redirect_valid = 1 in cycle N), takes priority over everything else:
  - FIFO is cleared; any pop or push in cycle N is ignored.
  - fetch_pc <= redirect_pc and rsp_pc <= redirect_pc.
  - discard_cnt <= outstanding + req_fire − imem_rsp_valid. Every request still in flight, including one issued in cycle N at the old PC, is stale.
  - A response arriving in cycle N is dropped.
- Back-to-back redirects, or a redirect while discard_cnt > 0, use the same formula. The last target wins.
- discard_cnt never underflows, because responses ≤ outstanding.
- Protocol error: a response with outstanding == 0 is illegal. Flag it with an assertion only.

Decomposition:
- Package fetch_pkg:
  - INSTR_BYTES = 4.
  - typedef fetch_entry_t {pc, instr} parametrised on XLEN (or a fixed 32-bit typedef plus localparams).
  - Function clog2-safe count width.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t, depth FIFO_DEPTH.
  - Ports push, pop, flush, count, head.
  - Async reset.
- Top level holds the PC, counters and the issue/discard logic.

Test Plan:
1. Reset release, imem_req_ready = 1, fixed 1-cycle memory latency, instr_ready = 1.
   -> Requests at 0x0, 0x4, 0x8, ... with ≤2 in flight.
   -> instr_valid first high 2 cycles after the first request; instr_pc increments by 4 each beat.
2. instr_ready = 0 with memory always ready.
   -> Exactly 4 responses accepted.
   -> imem_req_valid drops once outstanding + count = 4.
   -> No data lost after instr_ready returns to 1.
3. Memory latency 3 with 2 requests in flight, then redirect_pc = 0x100.
   -> Both stale responses are dropped.
   -> First instr_pc after the redirect is 0x100, with the data of the request at address 0x100.
4. Redirect in the same cycle as req_fire and imem_rsp_valid.
   -> discard_cnt equals outstanding + 1 − 1.
   -> FIFO is empty in the next cycle.
   -> No 0x-old PC ever reaches instr.
5. Two redirects in consecutive cycles (0x200 then 0x300), redirect_pc = 0x303.
   -> Stream resumes at 0x300.
   -> No instruction from 0x200 appears.
6. Assert reset mid-stream with FIFO full.
   -> Outputs go to reset values in the same cycle.
   -> After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pkg : shared types and sizing helpers for the fetch front end      |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_XLEN  = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_fifo : prefetch FIFO of fetched {pc, instr} entries, flushable     |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  parameter int  CNT_W   = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output entry_t           head
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  entry_t           mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    (push && !flush) |-> ((count_q != FULL_CNT) || pop));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : PC generation, credit-limited imem issue, redirect handling |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  localparam int              FCNT_W = cnt_width(FIFO_DEPTH);
  localparam int              OUT_W  = cnt_width(MAX_OUTSTANDING);
  localparam int              SUM_W  = cnt_width(FIFO_DEPTH + MAX_OUTSTANDING);
  localparam logic [XLEN-1:0] STEP   = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [OUT_W-1:0]  discard_q, discard_d;
  logic [FCNT_W-1:0] fifo_count;
  logic [SUM_W-1:0]  credit_used;
  logic [XLEN-1:0]   target_pc;
  logic [1:0]        unused_pc_lsbs;
  logic              req_fire, rsp_push, pop;
  entry_t            push_entry, head;

  assign target_pc      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_lsbs = redirect_pc[1:0];

  // Credits cover both in-flight words and buffered words, so every response fits.
  assign credit_used    = SUM_W'(outstanding_q) + SUM_W'(fifo_count);
  assign imem_req_valid = !reset
                          && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                          && (credit_used < SUM_W'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_push   = imem_rsp_valid && !redirect_valid && (discard_q == '0);
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
  assign pop        = instr_valid && instr_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid);
    if (redirect_valid) begin
      // Everything still owed by memory, including this cycle's issue, is stale.
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      discard_d  = outstanding_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (rsp_push) rsp_pc_d = rsp_pc_q + STEP;
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t),
    .CNT_W   (FCNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rsp_push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (head)
  );

  assign instr_valid    = (fifo_count != '0);
  assign instr          = head.instr;
  assign instr_pc       = head.pc;
  assign instr_pc_plus4 = head.pc + STEP;

  a_rsp_has_req: assert property (@(posedge clock) disable iff (reset)
    imem_rsp_valid |-> (outstanding_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : directed bench with stream-level model of fetch_unit     |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, instr_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mem_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          fires = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_req = RESET_PC;

  always #5 clock = ~clock;

  fetch_unit #(
    .XLEN            (32),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (MAX_OUT),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: fixed latency per request, in-order, one response per cycle.
  always @(posedge clock) begin
    cyc = cyc + 1;
    #2;
    if (reset) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Stream model: requests and delivered instructions each form a +4 sequence
  // that restarts at the (word-aligned) target of every redirect or reset.
  always @(negedge clock) begin
    int          inflight;
    logic [31:0] tgt;
    if (reset) begin
      exp_pc  = RESET_PC;
      exp_req = RESET_PC;
      fires   = 0;
      mem_q.delete();
    end else begin
      inflight = mem_q.size() + (imem_rsp_valid ? 1 : 0);
      check("credit_limit", {31'b0, imem_req_valid && (inflight >= MAX_OUT)}, 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req);
        exp_req = exp_req + 32'd4;
        fires++;
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      end
      if (redirect_valid) begin
        tgt     = {redirect_pc[31:2], 2'b00};
        exp_req = tgt;
        exp_pc  = tgt;
      end else if (instr_valid && instr_ready) begin
        check("instr_pc", instr_pc, exp_pc);
        check("instr", instr, mem_word(exp_pc));
        check("instr_pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int k = 0;
    @(negedge clock);
    while (!instr_valid && k < maxc) begin
      @(negedge clock);
      k++;
    end
    check(name, {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    // 1: streaming from reset, 1-cycle memory
    @(negedge clock);
    check("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("t1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t1_first_req_addr", imem_req_addr, 32'h0000_0000);
    @(negedge clock);
    check("t1_no_bypass", {31'b0, instr_valid}, 32'd0);
    @(negedge clock);
    check("t1_first_valid", {31'b0, instr_valid}, 32'd1);
    check("t1_first_pc", instr_pc, 32'h0000_0000);
    check("t1_first_instr", instr, 32'hC0DE_0000);
    run(8);
    imem_req_ready = 1'b0;
    run(3);
    imem_req_ready = 1'b1;
    run(10);

    // 2: decode stalled from reset; credits cap accepted words at FIFO depth
    instr_ready = 1'b0;
    pulse_reset();
    run(12);
    @(negedge clock);
    check("t2_fires", 32'(fires), 32'd4);
    check("t2_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
    check("t2_head_valid", {31'b0, instr_valid}, 32'd1);
    check("t2_head_pc", instr_pc, 32'h0000_0000);
    run(1);
    instr_ready = 1'b1;
    run(20);

    // 3: latency 3, redirect with two requests in flight
    lat = 3;
    pulse_reset();
    run(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clock);
    check("t3_inflight", 32'(mem_q.size() + (imem_rsp_valid ? 1 : 0)), 32'd2);
    run(1);
    redirect_valid = 1'b0;
    wait_valid("t3_resume_valid", 30);
    check("t3_resume_pc", instr_pc, 32'h0000_0100);
    check("t3_resume_instr", instr, 32'hC0DE_0100);
    run(15);

    // 4: redirect coinciding with a request fire and a response
    lat = 1;
    pulse_reset();
    run(6);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(negedge clock);
    check("t4_fire_same_cycle", {31'b0, imem_req_valid && imem_req_ready}, 32'd1);
    check("t4_rsp_same_cycle", {31'b0, imem_rsp_valid}, 32'd1);
    run(1);
    redirect_valid = 1'b0;
    @(negedge clock);
    check("t4_fifo_empty", {31'b0, instr_valid}, 32'd0);
    wait_valid("t4_resume_valid", 20);
    check("t4_resume_pc", instr_pc, 32'h0000_0040);
    check("t4_resume_instr", instr, 32'hC0DE_0040);
    run(8);

    // 5: back-to-back redirects, unaligned final target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    run(1);
    redirect_pc    = 32'h0000_0303;
    run(1);
    redirect_valid = 1'b0;
    wait_valid("t5_resume_valid", 20);
    check("t5_resume_pc", instr_pc, 32'h0000_0300);
    check("t5_resume_instr", instr, 32'hC0DE_0300);
    run(10);

    // 6: async reset with the FIFO full
    instr_ready = 1'b0;
    run(12);
    @(negedge clock);
    check("t6_full_valid", {31'b0, instr_valid}, 32'd1);
    check("t6_full_no_req", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("t6_async_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t6_async_instr_valid", {31'b0, instr_valid}, 32'd0);
    instr_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("t6_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t6_restart_addr", imem_req_addr, RESET_PC);
    run(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
